// File: rtl/qea_pkg.sv
// Shared definitions for the QEA state unloader: FSM encoding, amplitude field
// slot positions and the lane-slice helper used to pick amplitudes out of a RAM row.
package qea_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } qea_state_e;

  // A complex amplitude is {re, im}: re sits in the upper component slot.
  localparam int unsigned QEA_RE_SLOT = 1;
  localparam int unsigned QEA_IM_SLOT = 0;

  localparam int unsigned QEA_LAT_W = 3;

  // Lane 0 is the most significant slice of a row.
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned pe_num,
                                           int unsigned width);
    return (pe_num - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/qea_amp_serializer.sv
// Row buffer plus lane counter: holds one captured state RAM row and presents
// its amplitudes one lane at a time on a valid/ready stream.
module qea_amp_serializer
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int STATE_DATA_WIDTH = 64,
  parameter int ROW_WIDTH        = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] row_data,
  input  logic [ROW_WIDTH-1:0]               row_idx,
  input  logic                               last_row,
  input  logic                               amp_ready,
  output logic                               amp_valid,
  output logic [STATE_DATA_WIDTH-1:0]        amp_data,
  output logic [ROW_WIDTH+PE_NUM_WIDTH-1:0]  amp_index,
  output logic                               amp_last,
  output logic                               row_done
);

  logic [PE_NUM*STATE_DATA_WIDTH-1:0] row_buf;
  logic [PE_NUM_WIDTH-1:0]            lane;
  logic [ROW_WIDTH-1:0]               row_q;
  logic                               last_row_q;
  logic                               hs;
  logic                               lane_end;

  assign hs       = amp_valid && amp_ready;
  assign lane_end = (lane == PE_NUM_WIDTH'(PE_NUM - 1));
  assign row_done = hs && lane_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_buf    <= '0;
      lane       <= '0;
      row_q      <= '0;
      last_row_q <= 1'b0;
      amp_valid  <= 1'b0;
    end else if (load) begin
      row_buf    <= row_data;
      row_q      <= row_idx;
      last_row_q <= last_row;
      lane       <= '0;
      amp_valid  <= 1'b1;
    end else if (hs) begin
      if (lane_end) begin
        amp_valid <= 1'b0;
      end else begin
        lane <= lane + 1'b1;
      end
    end
  end

  // Data, index and last come straight from registers, so they hold during stalls.
  assign amp_data  = row_buf[lane_lsb(int'(lane), PE_NUM, STATE_DATA_WIDTH) +: STATE_DATA_WIDTH];
  assign amp_index = {row_q, lane};
  assign amp_last  = amp_valid && last_row_q && lane_end;

endmodule

// File: rtl/qea_state_unloader.sv
// Sweeps the QEA state RAM after a run and streams every amplitude with its basis index.
// Optional QEA_UNLOAD_NORM_EN adds a saturating sum-of-squares output o_norm_sq.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; illegal qubit count pulses o_error
// READ     | one-cycle RAM enable at the current row address
// WAIT     | RAM read latency; row is captured on the final cycle
// DRAIN    | serializer streams PE_NUM lanes of the captured row
// DONE     | one-cycle completion pulse
module qea_state_unloader
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int NUM_FRAC_BIT     = 30,
  parameter int RD_LATENCY       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_amp_valid,
  input  logic                                 i_amp_ready,
  output logic [STATE_DATA_WIDTH-1:0]          o_amp_data,
  output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_index,
  output logic                                 o_amp_last
`ifdef QEA_UNLOAD_NORM_EN
  ,
  output logic [2*DATA_WIDTH+7:0]              o_norm_sq
`endif
);

  localparam int RW = STATE_ADDR_WIDTH + 1;

  qea_state_e              state_q, state_n;
  logic [RW-1:0]           row_q;
  logic [RW-1:0]           row_last_q;
  logic [RW-1:0]           row_last_n;
  logic [QEA_LAT_W-1:0]    lat_q;
  logic                    err_q;
  logic [31:0]             q_w;
  logic                    q_legal;
  logic                    start_ok;
  logic                    last_row;
  logic                    capture;
  logic                    row_done;

  assign q_w      = 32'(i_qbit_num);
  assign q_legal  = (q_w >= 32'(PE_NUM_WIDTH)) &&
                    (q_w <= 32'(PE_NUM_WIDTH + STATE_ADDR_WIDTH));
  // Row counter is one bit wider than the address so the full-depth sweep never wraps.
  assign row_last_n = (RW'(1) << (q_w - 32'(PE_NUM_WIDTH))) - RW'(1);
  assign start_ok   = (state_q == ST_IDLE) && i_start && q_legal;
  assign last_row   = (row_q == row_last_q);
  assign capture    = (state_q == ST_WAIT) && (lat_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_n = ST_READ;
      ST_READ:  state_n = ST_WAIT;
      ST_WAIT:  if (lat_q == '0) state_n = ST_DRAIN;
      ST_DRAIN: if (row_done) state_n = last_row ? ST_DONE : ST_READ;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = 1'b0;
    o_state_ena   = '0;
    o_state_addra = '0;
    case (state_q)
      ST_READ: begin
        o_busy        = 1'b1;
        o_state_ena   = '1;
        o_state_addra = row_q[STATE_ADDR_WIDTH-1:0];
      end
      ST_WAIT, ST_DRAIN: o_busy = 1'b1;
      default: ;
    endcase
  end

  assign o_done      = (state_q == ST_DONE);
  assign o_error     = err_q;
  assign o_state_wea = '0;

  // Latency timer is a down-counter loaded in READ; terminal count triggers capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      row_last_q <= '0;
      lat_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && i_start && !q_legal;
      if (start_ok) begin
        row_q      <= '0;
        row_last_q <= row_last_n;
      end else if ((state_q == ST_DRAIN) && row_done && !last_row) begin
        row_q <= row_q + 1'b1;
      end
      if (state_q == ST_READ) begin
        lat_q <= QEA_LAT_W'(RD_LATENCY - 1);
      end else if ((state_q == ST_WAIT) && (lat_q != '0)) begin
        lat_q <= lat_q - 1'b1;
      end
    end
  end

  qea_amp_serializer #(
    .PE_NUM_WIDTH     (PE_NUM_WIDTH),
    .PE_NUM           (PE_NUM),
    .STATE_DATA_WIDTH (STATE_DATA_WIDTH),
    .ROW_WIDTH        (STATE_ADDR_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .row_data  (i_state_dout),
    .row_idx   (row_q[STATE_ADDR_WIDTH-1:0]),
    .last_row  (last_row),
    .amp_ready (i_amp_ready),
    .amp_valid (o_amp_valid),
    .amp_data  (o_amp_data),
    .amp_index (o_amp_index),
    .amp_last  (o_amp_last),
    .row_done  (row_done)
  );

`ifdef QEA_UNLOAD_NORM_EN
  localparam int NW     = 2 * DATA_WIDTH + 8;
  localparam int RE_OFS = QEA_RE_SLOT * DATA_WIDTH;
  localparam int IM_OFS = QEA_IM_SLOT * DATA_WIDTH;

  logic signed [2*DATA_WIDTH-1:0] re_x, im_x, re_sq, im_sq;
  logic [2*DATA_WIDTH:0]          mag;
  logic [NW:0]                    acc_sum;
  logic [NW-1:0]                  norm_q;

  assign re_x = {{DATA_WIDTH{o_amp_data[RE_OFS+DATA_WIDTH-1]}}, o_amp_data[RE_OFS +: DATA_WIDTH]};
  assign im_x = {{DATA_WIDTH{o_amp_data[IM_OFS+DATA_WIDTH-1]}}, o_amp_data[IM_OFS +: DATA_WIDTH]};
  assign re_sq   = re_x * re_x;
  assign im_sq   = im_x * im_x;
  assign mag     = {1'b0, re_sq} + {1'b0, im_sq};
  assign acc_sum = {1'b0, norm_q} + {{(NW - 2*DATA_WIDTH){1'b0}}, mag};

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      norm_q <= '0;
    end else if (o_amp_valid && i_amp_ready) begin
      norm_q <= acc_sum[NW] ? '1 : acc_sum[NW-1:0];
    end
  end

  assign o_norm_sq = norm_q;
`endif

endmodule

// File: tb/tb_qea_state_unloader.sv
// Scoreboard bench for qea_state_unloader: RAM models at latency 1 and 3,
// expected beats queued at start and popped on each accepted beat.
`timescale 1ns/1ps
module tb_qea_state_unloader;

  localparam int PW = 2, PE = 4, DW = 32, SDW = 64, AW = 16, QW = 6, IW = AW + PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3, ready;
  logic [QW-1:0] qbit;

  logic busy1, done1, err1, valid1, last1, busy3, done3, err3, valid3, last3;
  logic [PE-1:0] ena1, wea1, ena3, wea3;
  logic [AW-1:0] addr1, addr3;
  logic [PE*SDW-1:0] dout1, dout3;
  logic [SDW-1:0] data1, data3;
  logic [IW-1:0] idx1, idx3;
`ifdef QEA_UNLOAD_NORM_EN
  logic [2*DW+7:0] norm1, norm3;
`endif

  qea_state_unloader #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .i_start(start1), .i_qbit_num(qbit),
    .o_busy(busy1), .o_done(done1), .o_error(err1),
    .o_state_ena(ena1), .o_state_wea(wea1), .o_state_addra(addr1),
    .i_state_dout(dout1), .o_amp_valid(valid1), .i_amp_ready(ready),
    .o_amp_data(data1), .o_amp_index(idx1), .o_amp_last(last1)
`ifdef QEA_UNLOAD_NORM_EN
    , .o_norm_sq(norm1)
`endif
  );

  qea_state_unloader #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .i_start(start3), .i_qbit_num(qbit),
    .o_busy(busy3), .o_done(done3), .o_error(err3),
    .o_state_ena(ena3), .o_state_wea(wea3), .o_state_addra(addr3),
    .i_state_dout(dout3), .o_amp_valid(valid3), .i_amp_ready(ready),
    .o_amp_data(data3), .o_amp_index(idx3), .o_amp_last(last3)
`ifdef QEA_UNLOAD_NORM_EN
    , .o_norm_sq(norm3)
`endif
  );

  int mode = 0;

  function automatic logic [SDW-1:0] amp_val(int m, int row, int lane);
    logic [15:0] r16;
    r16 = 16'(row);
    case (m)
      0: return (row == 0 && lane == 0) ? 64'h40000000_00000000 : 64'h0;
      1: return {8'hC0 | 8'(lane), r16[7:0], 16'h1234, r16 ^ 16'hBEEF, 8'(lane), 8'h5A};
      default: return 64'h80000000_80000000;
    endcase
  endfunction

  function automatic logic [PE*SDW-1:0] row_word(int m, int row);
    logic [PE*SDW-1:0] w;
    w = '0;
    for (int k = 0; k < PE; k++) w[(PE-k)*SDW-1 -: SDW] = amp_val(m, row, k);
    return w;
  endfunction

  logic [PE*SDW-1:0] p1;
  logic [PE*SDW-1:0] p3 [3];
  always_ff @(posedge clk) begin
    if (ena1 != '0) p1 <= row_word(mode, int'(addr1));
    if (ena3 != '0) p3[0] <= row_word(mode, int'(addr3));
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout1 = p1;
  assign dout3 = p3[2];

  logic sel = 1'b0;
  logic m_valid, m_last, m_done, m_busy;
  logic [SDW-1:0] m_data;
  logic [IW-1:0] m_idx;
  logic [PE-1:0] m_ena, m_wea;
  logic [AW-1:0] m_addr;
  assign m_valid = sel ? valid3 : valid1;
  assign m_last  = sel ? last3  : last1;
  assign m_done  = sel ? done3  : done1;
  assign m_busy  = sel ? busy3  : busy1;
  assign m_data  = sel ? data3  : data1;
  assign m_idx   = sel ? idx3   : idx1;
  assign m_ena   = sel ? ena3   : ena1;
  assign m_wea   = sel ? wea3   : wea1;
  assign m_addr  = sel ? addr3  : addr1;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [SDW-1:0] data;
    logic [IW-1:0]  idx;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int beats = 0, reads = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, busy_cyc = 0;
  int first_ena_cyc = -1, first_valid_cyc = -1, exp_addr = 0;
  logic mon_en = 1'b0;
  logic p_stall = 1'b0;
  beat_t p_beat;

  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      check("wea_zero", 128'(m_wea), 128'(0));
      if (m_ena != '0) begin
        check("ram_ena_all", 128'(m_ena), 128'({PE{1'b1}}));
        check("ram_addr", 128'(m_addr), 128'(exp_addr));
        exp_addr++;
        reads++;
        if (first_ena_cyc < 0) first_ena_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (p_stall) begin
        check("stall_valid", 128'(m_valid), 128'(1));
        check("stall_stable", 128'({m_data, m_idx, m_last}), 128'(p_beat));
      end
      if (m_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", 128'(exp_q.size()), 128'(1));
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 128'(m_data), 128'(e.data));
          check("beat_idx", 128'(m_idx), 128'(e.idx));
          check("beat_last", 128'(m_last), 128'(e.last));
        end
        beats++;
        last_hs_cyc = cyc;
      end
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_not_busy", 128'(m_busy), 128'(0));
      end
      p_stall = m_valid && !ready;
      p_beat  = {m_data, m_idx, m_last};
    end
  end

  task automatic run_sweep(int q, int m, bit use3);
    int rows;
    beat_t b;
    rows = 1 << (q - PW);
    mode = m;
    sel = use3;
    exp_addr = 0;
    reads = 0;
    beats = 0;
    first_ena_cyc = -1;
    first_valid_cyc = -1;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < PE; k++) begin
        b.data = amp_val(m, r, k);
        b.idx  = IW'(r * PE + k);
        b.last = (r == rows - 1) && (k == PE - 1);
        exp_q.push_back(b);
      end
    end
    qbit = QW'(q);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    busy_cyc = cyc;
    check("busy_rise", 128'(m_busy), 128'(1));
  endtask

  task automatic wait_done(int budget, bit rand_rdy, string tag);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (rand_rdy) ready = 1'($urandom_range(0, 1));
      n++;
    end
    ready = 1'b1;
    check({tag, "_done_seen"}, 128'(done_cnt - d0), 128'(1));
    check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_done_after_last"}, 128'(done_cyc - last_hs_cyc), 128'(1));
  endtask

  initial begin
    int n;
    int d0;
    logic [71:0] all1;
    all1 = '1;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; ready = 1'b1; qbit = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 128'({busy1, done1, err1, ena1, wea1, addr1, valid1, idx1, last1}), 128'(0));
    check("reset_data", 128'(data1), 128'(0));
    check("reset_outs3", 128'({busy3, done3, err3, ena3, valid3, last3}), 128'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 9 qubits, single nonzero amplitude, ready tied high
    run_sweep(9, 0, 1'b0);
    wait_done(2000, 1'b0, "q9");
    check("q9_beats", 128'(beats), 128'(512));
    check("q9_reads", 128'(reads), 128'(128));
    check("q9_cycles", 128'(done_cyc - busy_cyc), 128'(128 * (PE + 2)));
    check("q9_lat1", 128'(first_valid_cyc - first_ena_cyc), 128'(2));
`ifdef QEA_UNLOAD_NORM_EN
    check("norm_2p60", 128'(norm1), 128'(72'h1 << 60));
`endif
    @(posedge clk); #1;
    check("idle_after_done", 128'({busy1, done1}), 128'(0));

    // random backpressure, 3 qubits
    run_sweep(3, 1, 1'b0);
    wait_done(400, 1'b1, "rand");
    check("rand_beats", 128'(beats), 128'(8));

    // illegal qubit counts
    for (int t = 0; t < 2; t++) begin
      reads = 0;
      qbit = (t == 0) ? QW'(1) : QW'(19);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("err_pulse", 128'(err1), 128'(1));
      check("err_busy", 128'(busy1), 128'(0));
      @(posedge clk); #1;
      check("err_one_cycle", 128'(err1), 128'(0));
      repeat (3) @(posedge clk);
      #1;
      check("err_no_read", 128'(reads), 128'(0));
      check("err_idle", 128'(busy1), 128'(0));
    end

    // read latency 3 instance
    run_sweep(3, 1, 1'b1);
    wait_done(200, 1'b0, "lat3");
    check("lat3_capture", 128'(first_valid_cyc - first_ena_cyc), 128'(4));
    check("lat3_cycles", 128'(done_cyc - busy_cyc), 128'(2 * (PE + 4)));
    check("lat3_reads", 128'(reads), 128'(2));
    sel = 1'b0;

    // reset during row 5 of a 9-qubit sweep
    run_sweep(9, 1, 1'b0);
    n = 0;
    while (!(valid1 && idx1[IW-1:PW] == AW'(5)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("row5_reached", 128'(idx1[IW-1:PW]), 128'(5));
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    check("midrst_outs", 128'({busy1, done1, err1, ena1, wea1, addr1, valid1, idx1, last1}), 128'(0));
    check("midrst_data", 128'(data1), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", 128'(done_cnt - d0), 128'(0));
    run_sweep(3, 1, 1'b0);
    wait_done(200, 1'b0, "restart");
    check("restart_beats", 128'(beats), 128'(8));

`ifdef QEA_UNLOAD_NORM_EN
    run_sweep(9, 2, 1'b0);
    wait_done(2000, 1'b0, "sat");
    check("norm_saturate", 128'(norm1), 128'(all1));
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qea_state_unloader.md
Name: qea_state_unloader

Overview:
- Read-back engine on the QEA state RAM port: after a run completes, it sweeps all state rows and serialises the PE_NUM complex amplitudes per row onto a valid/ready amplitude stream.
- Each beat carries its basis-state index.
- It is the read-side counterpart of the host-side state loader; it drives QEA i_state_ena/i_state_wea/i_state_addra and consumes o_state_dout.

Parameters:
PE_NUM_WIDTH, 2, log2 of PE_NUM
PE_NUM, 4, amplitudes per state RAM row
DATA_WIDTH, 32, real/imag component width (signed fixed point)
STATE_DATA_WIDTH, 64, one complex amplitude {re,im}
STATE_ADDR_WIDTH, 16, state RAM row address width
MAX_QBIT_WIDTH, 6, width of qubit count
NUM_FRAC_BIT, 30, fractional bits per component
RD_LATENCY, 1, state RAM read latency in cycles (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_start  in  1  start pulse (typically QEA o_complete)
i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, sampled at start
o_busy  out  1  sweep in progress
o_done  out  1  one-cycle pulse after last beat accepted
o_error  out  1  one-cycle pulse, illegal qbit_num at start
o_state_ena  out  PE_NUM  per-PE RAM enable (all bits equal)
o_state_wea  out  PE_NUM  per-PE write enable, always 0
o_state_addra  out  STATE_ADDR_WIDTH  row address
i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  row read data
o_amp_valid  out  1  amplitude beat valid
i_amp_ready  in  1  downstream ready
o_amp_data  out  STATE_DATA_WIDTH  {re[63:32], im[31:0]}
o_amp_index  out  STATE_ADDR_WIDTH+PE_NUM_WIDTH  basis index = {row, lane}
o_amp_last  out  1  final beat of sweep

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FSM to IDLE, counters cleared. Reset mid-sweep aborts; no done pulse.
- Rows per sweep R = 2^(qbit_num - PE_NUM_WIDTH).
- Legal qbit_num: PE_NUM_WIDTH <= q <= PE_NUM_WIDTH+STATE_ADDR_WIDTH. Otherwise: o_error pulses the cycle after start and the FSM stays IDLE.
- Lane mapping: lane k occupies i_state_dout[(PE_NUM-k)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH]. Lane 0 is the MSB slice, so amplitude |0> is row 0 lane 0.
- FSM:
  - IDLE: start sampled → READ. Start while busy is ignored.
  - READ: drive o_state_ena all-ones and o_state_addra=row for exactly 1 cycle → WAIT.
  - WAIT: count RD_LATENCY cycles, then capture the full row into a row buffer → DRAIN.
  - DRAIN: present lane k. On valid&&ready, k++. When lane PE_NUM-1 is accepted: if row==R-1 → DONE, else row++ → READ.
  - DONE: o_done=1 for 1 cycle, o_busy=0 → IDLE.
- Stream rules:
  - o_amp_valid, once high, stays high with data/index/last stable until ready.
  - ready may be held low arbitrarily long.
  - o_amp_last=1 only on index R*PE_NUM-1.
- Throughput: PE_NUM beats per row plus (1+RD_LATENCY) bubble cycles; no prefetch.
- Timing: o_busy rises the cycle after start and falls with the o_done cycle. The o_done cycle immediately follows acceptance of the last beat.
- o_state_wea is constant 0; the block never writes state RAM.
- Row counter is STATE_ADDR_WIDTH+1 bits so R=2^STATE_ADDR_WIDTH terminates without wrap.

Optional Feature:
- QEA_UNLOAD_NORM_EN defined:
  - Adds output o_norm_sq (2*DATA_WIDTH+8 bits, unsigned, 2*NUM_FRAC_BIT fractional bits) = Σ(re²+im²) over every accepted beat.
  - Accumulates on each handshake; cleared at start.
  - Saturates at all-ones instead of wrapping.
  - Valid (stable) from the o_done cycle until the next start.
- Undefined: port and multipliers absent; all other behaviour identical.

Decomposition:
- Shared package qea_pkg: FSM state encoding (IDLE, READ, WAIT, DRAIN, DONE), amplitude field slice constants (RE/IM offsets), lane-slice helper function.
- One natural sub-module: qea_amp_serializer (row buffer + lane counter + valid/ready output register). Controller FSM, address counter and latency counter stay in the top.

Test Plan:
- 9 qubits, RAM row0 lane0 = 64'h40000000_00000000, rest 0, ready tied 1 → 512 beats; index 0 data 64'h40000000_00000000; indices 1..511 zero; last on index 511; o_done one cycle later; 128 reads on addresses 0..127, wea always 0.
- Random ready (50%), 3 qubits, distinct row patterns → 8 beats, in-order indices 0..7; data/index stable during stalls; no duplicates or drops.
- i_qbit_num=1 and i_qbit_num=19 (addr width 16) → o_error pulse, o_busy stays 0, no RAM enable.
- RD_LATENCY=3 → capture 3 cycles after enable; data matches RAM model; per-row bubble = 4 cycles with ready=1.
- rst asserted during row 5 of a 9-qubit sweep → next cycle all outputs 0; new start restarts at index 0.
- With QEA_UNLOAD_NORM_EN, first-test state → o_norm_sq = 2^60 at o_done. All-max-magnitude state → saturates to all-ones.
